// File: rtl/clock_cnt_pkg.sv
// Shared types and field moduli for the digital clock counter datapath.
package clock_cnt_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HR24_MOD = 24;
    localparam int HR12_MOD = 12;

endpackage

// File: rtl/mod_step_alu.sv
// Combinational next-count arithmetic for the modulo up/down counter.
// MODCNT_SATURATE_EN selects clamping at the limits instead of wrap-around.
module mod_step_alu
    import clock_cnt_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  dir_e             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // One extra bit keeps count+s from overflowing before the modulus compare.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, count} + {1'b0, s};

`ifndef MODCNT_SATURATE_EN
    logic [WIDTH:0] w_sum_wrapped;
    logic [WIDTH:0] w_down_wrapped;
    assign w_sum_wrapped  = w_sum - MOD_EXT;
    assign w_down_wrapped = {1'b0, count} + MOD_EXT - {1'b0, s};
`endif

    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (dir == DIR_UP) begin
            if (w_sum >= MOD_EXT) begin
                wrap = 1'b1;
`ifdef MODCNT_SATURATE_EN
                next_count = MAX_VAL;
`else
                next_count = w_sum_wrapped[WIDTH-1:0];
`endif
            end else begin
                next_count = w_sum[WIDTH-1:0];
            end
        end else begin
            if (count >= s) begin
                next_count = count - s;
            end else begin
                wrap = 1'b1;
`ifdef MODCNT_SATURATE_EN
                next_count = '0;
`else
                next_count = w_down_wrapped[WIDTH-1:0];
`endif
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with programmable step, load and registered carry/borrow.
// Define MODCNT_SATURATE_EN to clamp at the limits instead of wrapping.
module mod_updown_counter
    import clock_cnt_pkg::*;
#(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = $clog2(MODULUS),
    parameter int STEP_W    = WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              carry,
    output logic              borrow,
    output logic              at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_borrow;

    logic [WIDTH-1:0] w_step_sat;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    dir_e             w_dir;

    // Out-of-range step and load values are clamped so the count never leaves 0..MODULUS-1.
    assign w_step_sat = (int'({1'b0, step}) >= MODULUS) ? MAX_VAL : WIDTH'(step);
    assign w_load_sat = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    assign w_dir      = dir_e'(up_down);

    mod_step_alu #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_alu (
        .count      (r_count),
        .s          (w_step_sat),
        .dir        (w_dir),
        .next_count (w_next),
        .wrap       (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count  <= RESET_CNT;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else if (load) begin
            r_count  <= w_load_sat;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else if (en) begin
            r_count  <= w_next;
            r_carry  <= w_wrap & (w_dir == DIR_UP);
            r_borrow <= w_wrap & (w_dir == DIR_DOWN);
        end else begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end
    end

    assign count  = r_count;
    assign carry  = r_carry;
    assign borrow = r_borrow;
    assign at_max = (r_count == MAX_VAL);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter with MODULUS=60.
// Wrap tests run in the default build; clamp tests run when MODCNT_SATURATE_EN is defined.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_down;
    logic [5:0] step;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] count;
    logic       carry;
    logic       borrow;
    logic       at_max;

    int tests = 0;
    int fails = 0;

    mod_updown_counter #(.MODULUS(60)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_down  (up_down),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .borrow   (borrow),
        .at_max   (at_max)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [5:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; up_down = 1'b0; step = 6'd0; load = 1'b0; load_val = 6'd0;
        tick(); tick();
        tests++;
        if (count !== 6'd0 || carry !== 1'b0 || borrow !== 1'b0 || at_max !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset: count=%0d carry=%b borrow=%b at_max=%b, expected 0/0/0/0", count, carry, borrow, at_max);
        end
        reset = 1'b1;
    endtask

    task automatic test_up_wrap();
        do_load(6'd58);
        en = 1'b1; up_down = 1'b0; step = 6'd1;
        tick();
        tests++;
        if (count !== 6'd59 || carry !== 1'b0 || at_max !== 1'b1) begin
            fails++;
            $display("[TB] FAIL up_to_59: count=%0d carry=%b at_max=%b, expected 59/0/1", count, carry, at_max);
        end
`ifndef MODCNT_SATURATE_EN
        tick();
        tests++;
        if (count !== 6'd0 || carry !== 1'b1 || at_max !== 1'b0) begin
            fails++;
            $display("[TB] FAIL up_wrap: count=%0d carry=%b at_max=%b, expected 0/1/0", count, carry, at_max);
        end
        en = 1'b0;
        tick();
        tests++;
        if (count !== 6'd0 || carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL carry_pulse: count=%0d carry=%b, expected 0/0", count, carry);
        end
`endif
        en = 1'b0;
    endtask

`ifndef MODCNT_SATURATE_EN
    task automatic test_step2();
        do_load(6'd59);
        en = 1'b1; up_down = 1'b0; step = 6'd2;
        tick();
        tests++;
        if (count !== 6'd1 || carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL step2_wrap: count=%0d carry=%b, expected 1/1", count, carry);
        end
        en = 1'b0;
        tick();
        tests++;
        if (count !== 6'd1 || carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL step2_hold: count=%0d carry=%b, expected 1/0", count, carry);
        end
    endtask

    task automatic test_down();
        do_load(6'd0);
        en = 1'b1; up_down = 1'b1; step = 6'd1;
        tick();
        tests++;
        if (count !== 6'd59 || borrow !== 1'b1 || carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL down_wrap1: count=%0d borrow=%b carry=%b, expected 59/1/0", count, borrow, carry);
        end
        do_load(6'd3);
        en = 1'b1; up_down = 1'b1; step = 6'd5;
        tick();
        tests++;
        if (count !== 6'd58 || borrow !== 1'b1) begin
            fails++;
            $display("[TB] FAIL down_wrap5: count=%0d borrow=%b, expected 58/1", count, borrow);
        end
        do_load(6'd30);
        en = 1'b1; up_down = 1'b1; step = 6'd7;
        tick();
        tests++;
        if (count !== 6'd23 || borrow !== 1'b0) begin
            fails++;
            $display("[TB] FAIL down_plain: count=%0d borrow=%b, expected 23/0", count, borrow);
        end
        en = 1'b0;
    endtask

    task automatic test_clamp();
        load = 1'b1; load_val = 6'd62; en = 1'b1; up_down = 1'b0; step = 6'd1;
        tick();
        load = 1'b0;
        tests++;
        if (count !== 6'd59 || carry !== 1'b0 || at_max !== 1'b1) begin
            fails++;
            $display("[TB] FAIL load_clamp: count=%0d carry=%b at_max=%b, expected 59/0/1", count, carry, at_max);
        end
        step = 6'd63;
        tick();
        tests++;
        if (count !== 6'd58 || carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL step_clamp: count=%0d carry=%b, expected 58/1", count, carry);
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_load(6'd10);
        en = 1'b1; up_down = 1'b0; step = 6'd59;
        tick();
        tests++;
        if (count !== 6'd9 || carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_first: count=%0d carry=%b, expected 9/1", count, carry);
        end
        tick();
        tests++;
        if (count !== 6'd8 || carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_second: count=%0d carry=%b, expected 8/1", count, carry);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_priority();
        do_load(6'd59);
        en = 1'b1; up_down = 1'b0; step = 6'd1;
        tick();
        reset = 1'b0; load = 1'b1; load_val = 6'd10;
        tick();
        tests++;
        if (count !== 6'd0 || carry !== 1'b0 || borrow !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_priority: count=%0d carry=%b borrow=%b, expected 0/0/0", count, carry, borrow);
        end
        reset = 1'b1; load = 1'b0; en = 1'b0;
    endtask
`else
    task automatic test_saturate();
        do_load(6'd59);
        en = 1'b1; up_down = 1'b0; step = 6'd1;
        tick();
        tests++;
        if (count !== 6'd59 || carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL sat_up1: count=%0d carry=%b, expected 59/1", count, carry);
        end
        tick();
        tests++;
        if (count !== 6'd59 || carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL sat_up2: count=%0d carry=%b, expected 59/1", count, carry);
        end
        do_load(6'd0);
        en = 1'b1; up_down = 1'b1; step = 6'd1;
        tick();
        tests++;
        if (count !== 6'd0 || borrow !== 1'b1 || carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sat_down: count=%0d borrow=%b carry=%b, expected 0/1/0", count, borrow, carry);
        end
        en = 1'b0;
    endtask
`endif

    task automatic test_zero_step();
        do_load(6'd20);
        en = 1'b1; up_down = 1'b0; step = 6'd0;
        tick();
        tests++;
        if (count !== 6'd20 || carry !== 1'b0 || borrow !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zero_step: count=%0d carry=%b borrow=%b, expected 20/0/0", count, carry, borrow);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
`ifndef MODCNT_SATURATE_EN
        test_step2();
        test_down();
        test_clamp();
        test_back_to_back();
        test_reset_priority();
`else
        test_saturate();
`endif
        test_zero_step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
